// File: rtl/rtc_pkg.sv
// rtc_pkg: shared DS1302 command constants, ASCII codes, scheduler states and width helper
package rtc_pkg;
  localparam logic [7:0] CMD_WP = 8'h8E;
  localparam logic [7:0] CMD_BWR = 8'hBE;
  localparam logic [7:0] CMD_BRD = 8'hBF;
  localparam logic [7:0] WP_CLR = 8'h00;
  localparam logic [7:0] WP_SET = 8'h80;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  typedef enum logic [2:0] {RST_CHK, IDLE, WP_OFF, BWR, WP_ON, BRD, FMT} state_e;
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rtc_sched_ctrl_if.sv
// rtc_sched_ctrl_if: command-level RTC transaction bus plus the UART byte stream
interface rtc_sched_ctrl_if #(parameter int NUM_REGS = 7);
  logic op_vld, op_wr, op_done, tx_vld, tx_rdy;
  logic [7:0] op_cmd, tx_data;
  logic [3:0] op_len;
  logic [8*NUM_REGS-1:0] op_wdata, op_rdata;
  modport master (
    output op_vld, op_wr, op_cmd, op_len, op_wdata, tx_data, tx_vld,
    input op_done, op_rdata, tx_rdy
  );
  modport slave (
    input op_vld, op_wr, op_cmd, op_len, op_wdata, tx_data, tx_vld,
    output op_done, op_rdata, tx_rdy
  );
endinterface

// File: rtl/rtc_ascii_fmt.sv
// rtc_ascii_fmt: serialises latched RTC registers as "hh hh .. hh\r\n" on a valid/ready byte stream
module rtc_ascii_fmt import rtc_pkg::*; #(
  parameter int NUM_REGS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [8*NUM_REGS-1:0] data_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_vld_o,
  input  logic                  tx_rdy_i,
  output logic                  done_o
);
  localparam int KW = cw(NUM_REGS);
  logic [8*NUM_REGS-1:0] data_q;
  logic [KW-1:0] k_q;
  logic [1:0] ph_q;
  logic run_q, adv, next_reg;
  logic [3:0] nib;
  logic [7:0] cur;
  // ph: 0 hi nibble, 1 lo nibble, 2 separator (SP or CR), 3 LF
  assign nib = data_q[{k_q, ~ph_q[0], 2'b00} +: 4];
  assign cur = ph_q[1] ? (ph_q[0] ? ASC_LF : (k_q == '0 ? ASC_CR : ASC_SP))
                       : (nib > 4'd9 ? 8'h37 + {4'h0, nib} : 8'h30 + {4'h0, nib});
  assign adv = run_q && (!tx_vld_o || tx_rdy_i);
  assign next_reg = ph_q == 2'd2 && k_q != '0;
  assign done_o = tx_vld_o && tx_rdy_i && !run_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_q <= '0;
      k_q <= '0;
      ph_q <= '0;
      run_q <= 1'b0;
      tx_data_o <= '0;
      tx_vld_o <= 1'b0;
    end else if (start_i) begin
      data_q <= data_i;
      k_q <= KW'(NUM_REGS - 1);
      ph_q <= '0;
      run_q <= 1'b1;
    end else if (adv) begin
      tx_data_o <= cur;
      tx_vld_o <= 1'b1;
      run_q <= ph_q != 2'd3;
      k_q <= next_reg ? k_q - 1'b1 : k_q;
      ph_q <= next_reg ? 2'd0 : ph_q + 2'd1;
    end else if (done_o) begin
      tx_vld_o <= 1'b0;
    end
endmodule

// File: rtl/rtc_sched_ctrl.sv
// rtc_sched_ctrl: schedules DS1302 init, polled/key reads and set-time writes with a watchdog;
// each read is printed as an ASCII line.
module rtc_sched_ctrl import rtc_pkg::*; #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int POLL_MS = 1000,
  parameter int NUM_REGS = 7,
  parameter int INIT_EN = 1,
  parameter logic [8*NUM_REGS-1:0] INIT_TIME = 56'h24_01_01_01_00_00_00,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  key_pulse,
  input  logic                  set_vld,
  input  logic [8*NUM_REGS-1:0] set_time,
  rtc_sched_ctrl_if.master      bus,
  output logic                  busy,
  output logic                  err
);
  localparam int DW = 8 * NUM_REGS;
  localparam int POLL_CYC = CLK_FREQ / 1000 * POLL_MS;
  localparam int WW = cw(TIMEOUT_CYC);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYC - 1);
  state_e state_q, state_d;
  logic issued_q, set_pend_q, rd_pend_q, err_q, busy_q;
  logic [WW-1:0] wd_q;
  logic [DW-1:0] set_time_q, wdata_q;
  logic wait_st, wr_st, done_ok, tmo, take_set, take_rd, poll, fmt_done;
  assign wr_st = state_q inside {WP_OFF, BWR, WP_ON};
  assign wait_st = wr_st || state_q == BRD;
  assign done_ok = wait_st && issued_q && bus.op_done;
  assign tmo = wait_st && issued_q && !bus.op_done && wd_q == WD_MAX;
  assign take_set = state_q == IDLE && set_pend_q;
  assign take_rd = state_q == IDLE && !set_pend_q && rd_pend_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      RST_CHK: state_d = INIT_EN != 0 ? WP_OFF : IDLE;
      IDLE:    state_d = set_pend_q ? WP_OFF : rd_pend_q ? BRD : IDLE;
      WP_OFF:  state_d = done_ok ? BWR : WP_OFF;
      BWR:     state_d = done_ok ? WP_ON : BWR;
      WP_ON:   state_d = done_ok ? IDLE : WP_ON;
      BRD:     state_d = done_ok ? FMT : BRD;
      FMT:     state_d = fmt_done ? IDLE : FMT;
      default: state_d = RST_CHK;
    endcase
    if (tmo) state_d = IDLE;
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q <= RST_CHK;
      issued_q <= 1'b0;
      wd_q <= '0;
      set_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      set_time_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      issued_q <= wait_st && state_d == state_q;
      wd_q <= (wait_st && issued_q) ? wd_q + 1'b1 : '0;
      set_pend_q <= set_vld || (set_pend_q && !take_set);
      rd_pend_q <= key_pulse || poll || (rd_pend_q && !take_rd);
      err_q <= tmo || (err_q && !done_ok);
      busy_q <= state_d != IDLE;
      if (set_vld) set_time_q <= set_time;
      if (state_q == RST_CHK) wdata_q <= INIT_TIME;
      else if (take_set) wdata_q <= set_time_q;
    end
  if (POLL_MS > 0) begin : g_poll
    localparam int PW = cw(POLL_CYC);
    localparam logic [PW-1:0] P_MAX = PW'(POLL_CYC - 1);
    logic [PW-1:0] cnt_q;
    always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) cnt_q <= '0;
      else cnt_q <= cnt_q == P_MAX ? '0 : cnt_q + 1'b1;
    assign poll = cnt_q == P_MAX;
  end else begin : g_nopoll
    assign poll = 1'b0;
  end
  assign bus.op_vld = wait_st && !issued_q;
  assign bus.op_wr = wr_st;
  assign bus.op_cmd = state_q == BRD ? CMD_BRD : state_q == BWR ? CMD_BWR : wr_st ? CMD_WP : 8'h00;
  assign bus.op_len = (state_q == BRD || state_q == BWR) ? 4'(NUM_REGS) : wr_st ? 4'd1 : 4'd0;
  assign bus.op_wdata = state_q == BWR ? wdata_q : state_q == WP_ON ? DW'(WP_SET) : DW'(WP_CLR);
  assign busy = busy_q;
  assign err = err_q;
  rtc_ascii_fmt #(.NUM_REGS(NUM_REGS)) u_fmt (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .start_i   (state_q == BRD && done_ok),
    .data_i    (bus.op_rdata),
    .tx_data_o (bus.tx_data),
    .tx_vld_o  (bus.tx_vld),
    .tx_rdy_i  (bus.tx_rdy),
    .done_o    (fmt_done)
  );
endmodule

// File: tb/tb_rtc_sched_ctrl.sv
// tb_rtc_sched_ctrl: directed bench with a 50-cycle RTC bus model and a UART byte monitor
module tb_rtc_sched_ctrl;
  localparam int N = 7, TMO = 300, LAT = 50;
  localparam logic [55:0] INIT_T = 56'h24_01_01_01_00_00_00;
  localparam logic [55:0] RD_VAL = 56'h24_12_31_03_23_59_58;
  localparam logic [55:0] SET_T = 56'h25_06_15_07_12_30_00;
  typedef struct packed {logic wr; logic [3:0] len; logic [7:0] cmd; logic [55:0] wd;} op_t;
  logic clk = 1'b0, rst = 1'b1, key_pulse = 1'b0, set_vld = 1'b0;
  logic [55:0] set_time = '0;
  logic busy, err;
  op_t ops[$];
  logic [7:0] tx_log[$];
  bit done_en = 1'b1;
  int lat_cnt = 0;
  int checks = 0, failures = 0;
  rtc_sched_ctrl_if #(.NUM_REGS(N)) bus ();
  rtc_sched_ctrl #(
    .CLK_FREQ(2_000_000), .POLL_MS(1), .NUM_REGS(N), .INIT_EN(1),
    .INIT_TIME(INIT_T), .TIMEOUT_CYC(TMO)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .key_pulse(key_pulse), .set_vld(set_vld),
    .set_time(set_time), .bus(bus), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_op(input int i, input logic wr, input logic [7:0] cmd, input logic [3:0] len, input logic [55:0] wd);
    op_t o;
    o = (i < ops.size()) ? ops[i] : '0;
    chk($sformatf("op%0d_hdr", i), {o.wr, o.len, o.cmd}, {wr, len, cmd});
    if (wr) chk($sformatf("op%0d_wdata", i), len == 4'd1 ? {48'h0, o.wd[7:0]} : o.wd, wd);
  endtask
  task automatic chk_line(input string tag, input int base);
    string s;
    logic [7:0] b;
    s = "24 12 31 03 23 59 58\r\n";
    for (int i = 0; i < 22; i++) begin
      b = (base + i < tx_log.size()) ? tx_log[base + i] : 8'h00;
      chk($sformatf("%s_b%0d", tag, i), b, s[i]);
    end
  endtask
  // bus model and byte monitor sample on the falling edge; stimulus changes just after the rising edge
  initial begin
    bus.op_done = 1'b0;
    bus.op_rdata = RD_VAL;
    forever begin
      @(negedge clk);
      if (bus.tx_vld && bus.tx_rdy) tx_log.push_back(bus.tx_data);
      bus.op_done = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        bus.op_done = lat_cnt == 0;
      end
      if (bus.op_vld) begin
        ops.push_back({bus.op_wr, bus.op_len, bus.op_cmd, bus.op_wdata});
        if (done_en) lat_cnt = LAT;
      end
    end
  end
  initial begin
    logic pb, changed;
    logic [7:0] hold_d;
    bus.tx_rdy = 1'b1;
    repeat (3) tick;
    chk("rst_op_vld", bus.op_vld, 0);
    chk("rst_op_cmd", bus.op_cmd, 0);
    chk("rst_tx_vld", bus.tx_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    for (int i = 0; i < 1000 && ops.size() < 3; i++) tick;
    chk("init_ops_seen", ops.size(), 3);
    pb = busy;
    for (int i = 0; i < 200 && !bus.op_done; i++) begin
      pb = busy;
      tick;
    end
    chk("last_init_done_seen", bus.op_done, 1);
    chk("busy_before_last_done", pb, 1);
    chk("busy_after_last_done", busy, 0);
    chk_op(0, 1'b1, 8'h8E, 4'd1, 56'h00);
    chk_op(1, 1'b1, 8'hBE, 4'd7, INIT_T);
    chk_op(2, 1'b1, 8'h8E, 4'd1, 56'h80);
    for (int i = 0; i < 3000 && ops.size() < 4; i++) tick;
    chk_op(3, 1'b0, 8'hBF, 4'd7, 56'h0);
    for (int i = 0; i < 500 && tx_log.size() < 8; i++) tick;
    bus.tx_rdy = 1'b0;
    hold_d = bus.tx_data;
    changed = 1'b0;
    for (int i = 0; i < 100; i++) begin
      key_pulse = i == 10 || i == 40 || i == 70;
      tick;
      if (bus.tx_data !== hold_d || bus.tx_vld !== 1'b1) changed = 1'b1;
    end
    key_pulse = 1'b0;
    chk("stall_hold", changed, 0);
    chk("stall_no_xfer", tx_log.size(), 8);
    bus.tx_rdy = 1'b1;
    for (int i = 0; i < 500 && tx_log.size() < 22; i++) tick;
    chk("line1_len", tx_log.size(), 22);
    chk_line("line1", 0);
    for (int i = 0; i < 500 && ops.size() < 5; i++) tick;
    chk_op(4, 1'b0, 8'hBF, 4'd7, 56'h0);
    for (int i = 0; i < 500 && tx_log.size() < 44; i++) tick;
    chk_line("line2", 22);
    repeat (100) tick;
    chk("one_extra_read", ops.size(), 5);
    chk("two_lines", tx_log.size(), 44);
    chk("idle_before_set", busy, 0);
    set_time = SET_T;
    set_vld = 1'b1;
    key_pulse = 1'b1;
    tick;
    set_vld = 1'b0;
    key_pulse = 1'b0;
    for (int i = 0; i < 1000 && ops.size() < 9; i++) tick;
    chk_op(5, 1'b1, 8'h8E, 4'd1, 56'h00);
    chk_op(6, 1'b1, 8'hBE, 4'd7, SET_T);
    chk_op(7, 1'b1, 8'h8E, 4'd1, 56'h80);
    chk_op(8, 1'b0, 8'hBF, 4'd7, 56'h0);
    for (int i = 0; i < 500 && tx_log.size() < 66; i++) tick;
    chk("line3_len", tx_log.size(), 66);
    for (int i = 0; i < 100 && busy; i++) tick;
    done_en = 1'b0;
    set_time = 56'h11_22_33_44_55_66_77;
    set_vld = 1'b1;
    tick;
    set_vld = 1'b0;
    for (int i = 0; i < 50 && ops.size() < 10; i++) tick;
    chk_op(9, 1'b1, 8'h8E, 4'd1, 56'h00);
    repeat (TMO - 5) tick;
    chk("err_pre_tmo", err, 0);
    chk("busy_pre_tmo", busy, 1);
    repeat (10) tick;
    chk("err_tmo", err, 1);
    chk("idle_after_tmo", busy, 0);
    repeat (100) tick;
    chk("no_wp_on_after_tmo", ops.size(), 10);
    done_en = 1'b1;
    key_pulse = 1'b1;
    tick;
    key_pulse = 1'b0;
    for (int i = 0; i < 20 && ops.size() < 11; i++) tick;
    chk_op(10, 1'b0, 8'hBF, 4'd7, 56'h0);
    chk("err_sticky", err, 1);
    for (int i = 0; i < 200 && !bus.op_done; i++) tick;
    chk("err_cleared", err, 0);
    for (int i = 0; i < 500 && busy; i++) tick;
    chk("line4_len", tx_log.size(), 88);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
